// File: rtl/window_minmax_16b_pkg.sv
`default_nettype none
// ============================================================================
// Module  : minmax_pkg
// Purpose : Shared constants and FSM state encoding for window_minmax_16b.
// Contents: DATA_W       - sample width (fixed at 16 to match comparator_16b)
//           WIN_LEN_DEF  - default number of samples per window
//           state_e      - IDLE / ACCUM / DONE
// Revision: 1.0 - initial release
// ============================================================================
package minmax_pkg;

  localparam int DATA_W      = 16;
  localparam int WIN_LEN_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : minmax_pkg
`default_nettype wire

// File: rtl/window_minmax_16b_if.sv
`default_nettype none
// ============================================================================
// Module  : window_minmax_16b_if
// Purpose : Sample-in / result-out bundle for window_minmax_16b.
// Ports   : start            - opens a window (one-cycle pulse)
//           in_valid/in_ready/in_data    - sample handshake
//           out_valid/out_ready          - result handshake
//           max_val/min_val/max_idx/min_idx - window result
//           busy             - block is in ACCUM or DONE
// Modports: master (producer/consumer side), slave (window_minmax_16b)
// Revision: 1.0 - initial release
// ============================================================================
interface window_minmax_16b_if #(
  parameter int WIN_LEN = minmax_pkg::WIN_LEN_DEF
);
  localparam int IDX_W = $clog2(WIN_LEN);

  logic                          start;
  logic                          in_valid;
  logic                          in_ready;
  logic [minmax_pkg::DATA_W-1:0] in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [minmax_pkg::DATA_W-1:0] max_val;
  logic [minmax_pkg::DATA_W-1:0] min_val;
  logic [IDX_W-1:0]              max_idx;
  logic [IDX_W-1:0]              min_idx;
  logic                          busy;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, max_val, min_val, max_idx, min_idx, busy
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, max_val, min_val, max_idx, min_idx, busy
  );

endinterface : window_minmax_16b_if
`default_nettype wire

// File: rtl/comparator_16b.sv
`default_nettype none
// ============================================================================
// Module  : comparator_16b
// Purpose : Existing unsigned 16-bit magnitude comparator consumed by
//           window_minmax_16b (reproduced here so the slice builds alone).
// Ports   : data_a, data_b - unsigned operands
//           a_gt_b, a_lt_b, a_eq_b - one-hot relation flags
// Revision: 1.0 - initial release
// ============================================================================
module comparator_16b (
  input  wire logic [15:0] data_a,
  input  wire logic [15:0] data_b,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b
);

  always_comb begin
    a_gt_b = (data_a >  data_b);
    a_lt_b = (data_a <  data_b);
    a_eq_b = (data_a == data_b);
  end

endmodule : comparator_16b
`default_nettype wire

// File: rtl/window_minmax_16b.sv
`default_nettype none
// ============================================================================
// Module  : window_minmax_16b
// Purpose : Streaming min/max tracker over a window of WIN_LEN unsigned
//           16-bit samples; reports max/min and their window indices on a
//           registered valid/ready result port.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - window_minmax_16b_if.slave (sample in, result out)
// Config  : MINMAX_TIE_LATEST_EN - when defined, a sample equal to the stored
//           max/min moves the index to the latest occurrence; otherwise the
//           earliest index is kept.
// Revision: 1.0 - initial release
// ============================================================================
module window_minmax_16b
  import minmax_pkg::*;
#(
  parameter int WIN_LEN = WIN_LEN_DEF
) (
  input wire logic            clk,
  input wire logic            rst_n,
  window_minmax_16b_if.slave  bus
);

  localparam int               IDX_W    = $clog2(WIN_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   max_q, max_d, min_q, min_d;
  logic [IDX_W-1:0]    max_idx_q, max_idx_d, min_idx_q, min_idx_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic                max_gt, max_lt, max_eq;
  logic                min_gt, min_lt, min_eq;
  logic                accept;
  logic                unused_flags;

  comparator_16b u_cmp_max (
    .data_a (bus.in_data),
    .data_b (max_q),
    .a_gt_b (max_gt),
    .a_lt_b (max_lt),
    .a_eq_b (max_eq)
  );

  comparator_16b u_cmp_min (
    .data_a (bus.in_data),
    .data_b (min_q),
    .a_gt_b (min_gt),
    .a_lt_b (min_lt),
    .a_eq_b (min_eq)
  );

  // Opposite-direction flags are never needed; eq flags only with ties-latest.
  assign unused_flags = ^{max_lt, min_gt, max_eq, min_eq};

  // in_ready_q is only high in ACCUM, so it doubles as the state qualifier.
  assign accept = in_ready_q & bus.in_valid;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACCUM;
          count_d = '0;
        end
      end

      ACCUM: begin
        if (accept) begin
          if (count_q == '0) begin
            // The first sample seeds both trackers; flags against stale
            // stored values are irrelevant here.
            max_d     = bus.in_data;
            min_d     = bus.in_data;
            max_idx_d = '0;
            min_idx_d = '0;
          end else begin
            if (max_gt) begin
              max_d     = bus.in_data;
              max_idx_d = count_q;
            end
`ifdef MINMAX_TIE_LATEST_EN
            else if (max_eq) begin
              max_idx_d = count_q;
            end
`endif
            if (min_lt) begin
              min_d     = bus.in_data;
              min_idx_d = count_q;
            end
`ifdef MINMAX_TIE_LATEST_EN
            else if (min_eq) begin
              min_idx_d = count_q;
            end
`endif
          end

          if (count_q == LAST_IDX) begin
            state_d = DONE;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end

      DONE: begin
        // A start coincident with the result handshake chains windows
        // back-to-back; start alone is ignored while a result is pending.
        if (out_valid_q && bus.out_ready) begin
          state_d = bus.start ? ACCUM : IDLE;
          count_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    // Status flags are registered from the next state so every output
    // leaves the block straight from a flop.
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      max_q       <= '0;
      min_q       <= '0;
      max_idx_q   <= '0;
      min_idx_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      max_q       <= max_d;
      min_q       <= min_d;
      max_idx_q   <= max_idx_d;
      min_idx_q   <= min_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.max_val   = max_q;
  assign bus.min_val   = min_q;
  assign bus.max_idx   = max_idx_q;
  assign bus.min_idx   = min_idx_q;

endmodule : window_minmax_16b
`default_nettype wire

// File: tb/tb_window_minmax_16b.sv
`default_nettype none
// ============================================================================
// Module  : tb_window_minmax_16b
// Purpose : Self-checking bench for window_minmax_16b with WIN_LEN=4.
//           Directed windows plus randomized windows, compared against a
//           reference computed from the whole window (max/min, then the
//           earliest or latest position holding that value).
// Revision: 1.0 - initial release
// ============================================================================
module tb_window_minmax_16b;
  import minmax_pkg::*;

  localparam int WL = 4;
  localparam int IW = $clog2(WL);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  window_minmax_16b_if #(.WIN_LEN(WL)) bus ();

  window_minmax_16b #(.WIN_LEN(WL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0]   win [WL];
  logic [15:0]   e_max, e_min;
  logic [IW-1:0] e_maxi, e_mini;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: extreme values first, then the position of that value.
  task automatic model();
    e_max = win[0];
    e_min = win[0];
    for (int i = 1; i < WL; i++) begin
      if (win[i] > e_max) e_max = win[i];
      if (win[i] < e_min) e_min = win[i];
    end
`ifdef MINMAX_TIE_LATEST_EN
    for (int i = 0; i < WL; i++) begin
      if (win[i] == e_max) e_maxi = IW'(i);
      if (win[i] == e_min) e_mini = IW'(i);
    end
`else
    for (int i = WL - 1; i >= 0; i--) begin
      if (win[i] == e_max) e_maxi = IW'(i);
      if (win[i] == e_min) e_mini = IW'(i);
    end
`endif
  endtask

  task automatic open_window();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("open_in_ready", bus.in_ready, 1);
    check("open_busy", bus.busy, 1);
    check("open_out_valid", bus.out_valid, 0);
  endtask

  task automatic feed(input bit gaps);
    for (int i = 0; i < WL; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          bus.in_data  = 16'($urandom);
          @(negedge clk);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = win[i];
      check("acc_in_ready", bus.in_ready, 1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 16'($urandom);
  endtask

  task automatic check_result(input string tag);
    model();
    check({tag, "_out_valid"}, bus.out_valid, 1);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_max_val"}, bus.max_val, e_max);
    check({tag, "_min_val"}, bus.min_val, e_min);
    check({tag, "_max_idx"}, bus.max_idx, e_maxi);
    check({tag, "_min_idx"}, bus.min_idx, e_mini);
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("hs_out_valid", bus.out_valid, 0);
    check("hs_busy", bus.busy, 0);
    check("hs_in_ready", bus.in_ready, 0);
  endtask

  task automatic rand_win(input bit narrow);
    for (int i = 0; i < WL; i++) begin
      if (narrow) win[i] = 16'($urandom_range(0, 3)) * 16'h5555;
      else        win[i] = 16'($urandom);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_max_val", bus.max_val, 0);
    check("rst_min_val", bus.min_val, 0);
    check("rst_max_idx", bus.max_idx, 0);
    check("rst_min_idx", bus.min_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 0);

    // Directed: mixed values
    win = '{16'h04F8, 16'h04F7, 16'h04FA, 16'h24FA};
    open_window();
    feed(1'b0);
    check_result("dirA");
    check("dirA_max_lit", bus.max_val, 16'h24FA);
    check("dirA_min_lit", bus.min_val, 16'h04F7);
    handshake();

    // Directed: all equal (ties)
    win = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    open_window();
    feed(1'b0);
    check_result("ties");
    handshake();

    // Directed: extreme values
    win = '{16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF};
    open_window();
    feed(1'b0);
    check_result("extremes");
    check("ext_max_idx_lit", bus.max_idx, 0);
    check("ext_min_idx_lit", bus.min_idx, 1);

    // Hold result in DONE with start pulses; must stay put
    for (int k = 0; k < 5; k++) begin
      bus.start = k[0];
      @(negedge clk);
      check_result("hold");
    end
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    check("chain_out_valid", bus.out_valid, 0);
    check("chain_in_ready", bus.in_ready, 1);
    check("chain_busy", bus.busy, 1);
    rand_win(1'b0);
    feed(1'b0);
    check_result("chain");
    handshake();

    // in_valid gaps with noise on in_data
    rand_win(1'b0);
    open_window();
    feed(1'b1);
    check_result("gaps");
    handshake();

    // Asynchronous reset mid-window
    win[0] = 16'h0001;
    win[1] = 16'hFFFE;
    open_window();
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = win[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", bus.in_ready, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_max_val", bus.max_val, 0);
    check("arst_min_val", bus.min_val, 0);
    check("arst_max_idx", bus.max_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    win = '{16'h5000, 16'h6000, 16'h5500, 16'h5800};
    open_window();
    feed(1'b0);
    check_result("post_rst");
    handshake();

    // Randomized windows, some drawn from a small value set to force ties
    for (int w = 0; w < 12; w++) begin
      rand_win(w[0]);
      open_window();
      feed(w[1]);
      check_result("rand");
      handshake();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_window_minmax_16b
`default_nettype wire

// File: doc/window_minmax_16b.md
Name: window_minmax_16b

Overview:
- Streaming min/max tracker that sits directly upstream of comparator_16b and consumes its flags.
- It accepts a window of WIN_LEN 16-bit unsigned samples over a valid/ready handshake.
- Per sample it drives two comparator_16b instances: the sample against the running max, and the sample against the running min.
- At window end it presents max, min and their sample indices on a registered valid/ready result port.

Parameters:
- DATA_W, 16: sample width. Fixed at 16 to match comparator_16b.
- WIN_LEN, 8: samples per window. Legal range 2..65536.
- IDX_W, $clog2(WIN_LEN): width of the index and counter fields.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that opens a window.
- in_valid  in  1  sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  16  unsigned sample.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- max_val  out  16  largest sample in the window.
- min_val  out  16  smallest sample in the window.
- max_idx  out  IDX_W  window index of max_val.
- min_idx  out  IDX_W  window index of min_val.
- busy  out  1  high in ACCUM or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; count=0.
  - in_ready=0, out_valid=0, busy=0.
  - max_val, min_val, max_idx, min_idx all 0.
  - An in-progress window is discarded with no partial result.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0.
  - start=1 -> ACCUM next cycle; count cleared.
- ACCUM:
  - in_ready=1; start is ignored.
  - A sample is accepted on a cycle with in_valid & in_ready.
  - First accepted sample (count==0): max_val=min_val=in_data, both idx=0.
  - Later samples:
    - a_gt_b from the (in_data vs max_val) comparator -> load max_val and max_idx=count.
    - a_lt_b from the (in_data vs min_val) comparator -> load min_val and min_idx=count.
    - Both updates may occur in the same cycle only on the first sample.
    - Equality (a_eq_b) keeps the stored value and index.
  - count increments on each accept.
  - Accept with count==WIN_LEN-1 -> DONE next cycle.
  - in_valid gaps stall with no state change.
- DONE:
  - in_ready=0, out_valid=1.
  - Result outputs are stable until the handshake.
  - out_valid & out_ready -> IDLE, out_valid=0.
  - If start=1 in the same cycle as the handshake -> ACCUM directly, count=0.
  - start without out_ready is ignored.
- Latency: out_valid rises on the clock edge after the last accepted sample (1 cycle).
- Throughput: 1 sample/cycle. Minimum window cost is WIN_LEN+1 cycles plus the handshake cycle.
- All outputs are registered. No combinational path from in_valid to in_ready.
- All comparisons are unsigned 16-bit. 0x0000 and 0xFFFF need no special case.

Optional Feature:
- Macro: MINMAX_TIE_LATEST_EN.
- Defined: on a_eq_b against the stored max (or min), update max_idx (or min_idx) to the current count. The value is unchanged, so the index tracks the latest occurrence.
- Undefined: ties keep the earliest index.

Decomposition:
- Package minmax_pkg holds:
  - DATA_W.
  - State enum/localparams IDLE=2'd0, ACCUM=2'd1, DONE=2'd2.
  - Default WIN_LEN.
- Sub-module: two instances of the existing comparator_16b, connected by name (data_a=in_data, data_b=stored value). No new sub-module is written.

Test Plan:
- WIN_LEN=4, samples 0x04F8, 0x04F7, 0x04FA, 0x24FA -> max_val=0x24FA idx 3; min_val=0x04F7 idx 1; out_valid one cycle after the 4th accept.
- Samples 0x0100 x4 -> max=min=0x0100, both idx 0. With MINMAX_TIE_LATEST_EN: both idx 3.
- Samples 0xFFFF, 0x0000, 0x8000, 0x7FFF -> max 0xFFFF idx 0, min 0x0000 idx 1.
- Hold out_ready=0 for 5 cycles in DONE:
  - Outputs stay stable; in_ready=0; start pulses are ignored.
  - out_ready=1 together with start=1 -> next cycle ACCUM, out_valid=0.
- in_valid toggling 1,0,0,1,... -> only handshaken samples count; indices follow accept order.
- rst_n low after 2 of 4 samples -> all outputs 0 and IDLE immediately (async). Next window is computed fresh with no carry-over.
